breathe_pwm: RTL and testbench
==============================

# breathe_pwm

- Drives an LED with a "breathing" brightness envelope.
- Sits directly downstream of `clockdivider`: the divider's `clkout` pulse, sampled in the `clkin` domain, arrives as `tick` and paces the envelope.
- A free-running PWM counter on `clkin` sets instantaneous brightness.
- An envelope state machine ramps the duty up, holds, ramps down and holds again, one step per `STEP_TICKS` ticks.

## Interface

Parameters:
- `PWM_BITS`, default 8: width of the PWM counter and duty; period is 2^PWM_BITS `clkin` cycles.
- `STEP_TICKS`, default 4: ticks per envelope step; must be ≥1.
- `HOLD_STEPS`, default 16: steps spent in each hold phase; must be ≥1.

Ports:
- `clkin`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `tick`, input, 1: envelope pacing strobe, one `clkin` cycle wide, synchronous to `clkin`.
- `en`, input, 1: run enable.
- `ledout`, output, 1: registered PWM output.
- `duty`, output, PWM_BITS: current envelope target duty.
- `phase`, output, 2: envelope state (0 RAMP_UP, 1 HOLD_HIGH, 2 RAMP_DOWN, 3 HOLD_LOW).

## Operation

Reset and enable:
- Reset values: `ledout`=0, `duty`=0, `phase`=RAMP_UP, PWM counter=0, tick counter=0, hold counter=0, latched duty=0.
- Reset wins over every other input on the same edge.
- `en`=0: the PWM counter clears to 0, `ledout` registers 0, and all envelope state freezes, including the tick count.
- `tick` is ignored while `en`=0.

PWM:
- The counter increments every enabled cycle and wraps from 2^PWM_BITS−1 to 0.
- Next `ledout` = (counter < latched duty).
- The latched duty loads from the effective duty only in the cycle the counter equals 2^PWM_BITS−1, so each PWM period uses one duty (glitch-free).
- Latched duty 0 gives constant 0. Latched duty 2^PWM_BITS−1 gives high for all but one cycle per period.

Step generation:
- Tick counter range is 0..STEP_TICKS−1.
- On `tick` with the counter at STEP_TICKS−1, the counter returns to 0 and a step event fires. Otherwise `tick` increments the counter.

State machine, acting on step events only:
- RAMP_UP: `duty`+1. At step where `duty` becomes max → HOLD_HIGH, hold counter = 0.
- HOLD_HIGH: hold counter+1. When it reaches HOLD_STEPS → RAMP_DOWN.
- RAMP_DOWN: `duty`−1. At step where `duty` becomes 0 → HOLD_LOW, hold counter = 0.
- HOLD_LOW: as HOLD_HIGH → RAMP_UP.
- `duty` never wraps; the saturating transition and the state change happen on the same edge.

## Timing

- `ledout` lags the PWM counter by one register: counter value N in cycle t determines `ledout` in cycle t+1.
- A `duty` change reaches `ledout` at the next PWM period boundary, at most 2^PWM_BITS+1 cycles later.
- `duty` and `phase` update on the edge following the qualifying `tick`.
- Full cycle length is 2·(2^PWM_BITS−1)·STEP_TICKS + 2·HOLD_STEPS·STEP_TICKS ticks.
- Reset asserted mid-ramp: all state is at reset values on the next edge. Ramping restarts from duty 0 once `rst` falls.
- `en` rising: the PWM counter starts from 0 in that cycle. `ledout` follows the latched duty, which is retained through `en`=0.

## Configuration

- `BREATHE_GAMMA_EN` defined: effective duty = (`duty`·`duty`) >> PWM_BITS.
  - The product is computed at 2·PWM_BITS width.
  - Special case: `duty`=max maps to max.
  - Gives a perceptually linear fade.
- Not defined: effective duty = `duty`.
- The `duty` output always shows the uncorrected target.

## Structure

- Package `breathe_pkg`:
  - phase enum with the 2-bit encodings above;
  - PHASE_W constant = 2.
- One sub-module, `pwm_core`: PWM counter, period-boundary duty latch and the registered `ledout` compare, parameterised by PWM_BITS.
- The envelope FSM, tick counter, hold counter and gamma mapping live in `breathe_pwm`.

## Test plan

All scenarios use PWM_BITS=4, STEP_TICKS=2, HOLD_STEPS=3.

- Reset: hold `rst` 3 cycles, `tick` high → `ledout`=0, `duty`=0, `phase`=0 throughout and on release.
- Ramp stepping: `en`=1, `tick` every 4th cycle → `duty` increments on every 2nd tick. Reaches 15 after 30 ticks; `phase`=1 on that same edge.
- Holds and ramp down: continue ticking → `phase`=2 after 6 further ticks. `duty` 15→0 over 30 ticks, then `phase`=3, then `phase`=0 after 6 ticks.
- PWM shape: force `duty`=5 by pausing ticks → each 16-cycle period has exactly 5 high cycles. A mid-period duty change takes effect only from the next period start.
- Enable and reset mid-operation: drop `en` at `duty`=7 → `ledout`=0, `duty` stays 7, ticks ignored. Re-raise `en` → ramp resumes from 7. Assert `rst` at `duty`=9 → `duty`=0 next edge.
- Gamma (run with `BREATHE_GAMMA_EN` defined): `duty`=8 → 4 high cycles per period; `duty`=15 → 15 high cycles; `duty`=3 → 0 high cycles.

Source files
------------

// File: rtl/breathe_pkg.sv
// breathe_pkg: shared phase encoding for the breathing LED envelope.
package breathe_pkg;
    localparam int PHASE_W = 2;
    typedef enum logic [PHASE_W-1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HIGH = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LOW  = 2'd3
    } phase_t;
endpackage

// File: rtl/breathe_pwm_pwm_core.sv
// pwm_core: free-running PWM counter, period-boundary duty latch and registered compare.
module pwm_core
    import breathe_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                ledout
);
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] lat;
    // lat survives en=0 so a resumed period keeps its last brightness
    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt    <= '0;
            lat    <= '0;
            ledout <= 1'b0;
        end else if (!en) begin
            cnt    <= '0;
            ledout <= 1'b0;
        end else begin
            cnt    <= cnt + 1'b1;
            ledout <= cnt < lat;
            if (&cnt)
                lat <= duty_in;
        end
    end
endmodule

// File: rtl/breathe_pwm.sv
// breathe_pwm: tick-paced breathing envelope FSM driving a glitch-free PWM LED.
// Define BREATHE_GAMMA_EN to square the duty before it reaches the PWM compare.
module breathe_pwm
    import breathe_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP_TICKS = 4,
    parameter int HOLD_STEPS = 16
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic                tick,
    input  logic                en,
    output logic                ledout,
    output logic [PWM_BITS-1:0] duty,
    output logic [PHASE_W-1:0]  phase
);
    localparam int TW = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [PWM_BITS-1:0] DMAX = '1;
    phase_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_d;
    logic [HW-1:0]       hold_q, hold_d, hold_inc;
    logic [TW-1:0]       tcnt_q;
    logic                tick_last, step;
    logic [PWM_BITS-1:0] eff;
    assign tick_last = tcnt_q == TW'(STEP_TICKS - 1);
    assign step      = en && tick && tick_last;
    assign hold_inc  = hold_q + 1'b1;
    assign phase     = state_q;
    always_ff @(posedge clkin) begin
        if (rst) begin
            tcnt_q  <= '0;
            state_q <= RAMP_UP;
            duty    <= '0;
            hold_q  <= '0;
        end else begin
            if (en && tick)
                tcnt_q <= tick_last ? '0 : tcnt_q + 1'b1;
            state_q <= state_d;
            duty    <= duty_d;
            hold_q  <= hold_d;
        end
    end
    // saturation and phase change land on the same step
    always_comb begin
        state_d = state_q;
        duty_d  = duty;
        hold_d  = hold_q;
        if (step) begin
            case (state_q)
                RAMP_UP: begin
                    duty_d = duty + 1'b1;
                    if (duty == DMAX - 1'b1) begin
                        state_d = HOLD_HIGH;
                        hold_d  = '0;
                    end
                end
                HOLD_HIGH: begin
                    hold_d  = hold_inc;
                    state_d = hold_inc == HW'(HOLD_STEPS) ? RAMP_DOWN : HOLD_HIGH;
                end
                RAMP_DOWN: begin
                    duty_d = duty - 1'b1;
                    if (duty == PWM_BITS'(1)) begin
                        state_d = HOLD_LOW;
                        hold_d  = '0;
                    end
                end
                default: begin
                    hold_d  = hold_inc;
                    state_d = hold_inc == HW'(HOLD_STEPS) ? RAMP_UP : HOLD_LOW;
                end
            endcase
        end
    end
`ifdef BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
    assign eff = duty == DMAX ? DMAX : PWM_BITS'(sq >> PWM_BITS);
`else
    assign eff = duty;
`endif
    pwm_core #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clkin  (clkin),
        .rst    (rst),
        .en     (en),
        .duty_in(eff),
        .ledout (ledout)
    );
endmodule

// File: tb/tb_breathe_pwm.sv
// tb_breathe_pwm: directed plus random stimulus against an arithmetic envelope/PWM reference.
module tb_breathe_pwm;
    localparam int PB = 4, ST = 2, HS = 3, MAXD = 15, CYC = 2 * MAXD + 2 * HS;
    logic clkin = 1'b0, rst = 1'b1, tick = 1'b0, en = 1'b0;
    logic ledout;
    logic [PB-1:0] duty;
    logic [1:0] phase;
    int n_assert = 0, n_fail = 0;
    int ticks = 0, m_cnt = 0, m_lat = 0, hi = 0;
    logic m_led = 1'b0;

    breathe_pwm #(.PWM_BITS(PB), .STEP_TICKS(ST), .HOLD_STEPS(HS)) dut (
        .clkin (clkin),
        .rst   (rst),
        .tick  (tick),
        .en    (en),
        .ledout(ledout),
        .duty  (duty),
        .phase (phase)
    );

    always #5 clkin = ~clkin;

    // envelope position derived purely from the number of steps since reset
    function automatic int exp_duty(input int t);
        int p = (t / ST) % CYC;
        if (p < MAXD) return p;
        if (p < MAXD + HS) return MAXD;
        if (p < 2 * MAXD + HS) return MAXD - (p - MAXD - HS);
        return 0;
    endfunction

    function automatic int exp_phase(input int t);
        int p = (t / ST) % CYC;
        if (p < MAXD) return 0;
        if (p < MAXD + HS) return 1;
        if (p < 2 * MAXD + HS) return 2;
        return 3;
    endfunction

    function automatic int eff(input int d);
`ifdef BREATHE_GAMMA_EN
        return d == MAXD ? MAXD : (d * d) >> PB;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic t);
        rst = r;
        en = e;
        tick = t;
        @(posedge clkin);
        if (r) begin
            ticks = 0;
            m_cnt = 0;
            m_lat = 0;
            m_led = 1'b0;
        end else if (e) begin
            m_led = m_cnt < m_lat;
            if (m_cnt == MAXD) m_lat = eff(exp_duty(ticks));
            m_cnt = (m_cnt + 1) % (MAXD + 1);
            if (t) ticks++;
        end else begin
            m_cnt = 0;
            m_led = 1'b0;
        end
        @(negedge clkin);
        chk("duty", duty, exp_duty(ticks));
        chk("phase", phase, exp_phase(ticks));
        chk("ledout", ledout, m_led);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1);
        chk("rst_duty", duty, 0);
        chk("rst_phase", phase, 0);
        chk("rst_led", ledout, 0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("ramp_top_duty", duty, 15);
        chk("ramp_top_phase", phase, 1);
        for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("hold_high_exit", phase, 2);
        for (int i = 0; i < 120; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("ramp_bottom_duty", duty, 0);
        chk("ramp_bottom_phase", phase, 3);
        for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("hold_low_exit", phase, 0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("pwm_duty5", duty, 5);
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 1'b0);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            hi += int'(ledout);
        end
        chk("pwm_high5", hi, eff(5));
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 1'b0);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            hi += int'(ledout);
        end
        chk("pwm_high6", hi, eff(6));
        for (int i = 0; i < 400; i++)
            cyc(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 56; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("en_duty7", duty, 7);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, i % 2 == 0);
        chk("en_off_duty", duty, 7);
        chk("en_off_led", ledout, 0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("en_resume", duty, 8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("pre_rst_duty", duty, 9);
        cyc(1'b1, 1'b1, 1'b1);
        chk("mid_rst_duty", duty, 0);
        chk("mid_rst_phase", phase, 0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, i % 4 == 3);
        chk("restart_duty", duty, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
